// File: rtl/feat_concat_stream.sv
// feat_concat_stream
// Collects up to three parallel input vectors per frame (each with its own
// valid/ready handshake) and streams their concatenation one element per
// beat with backpressure. A disabled source is never waited for and its
// slot range streams as zeros.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   src_en[2:0]               per-source enable, sampled only between frames
//   sK_vec/sK_valid/sK_ready  source K vector (element j at [j*DW +: DW])
//   out_data/out_valid/out_ready  element stream
//   out_index                 slot index of out_data (0..TOTAL-1)
//   out_last                  high with slot TOTAL-1
//   busy                      high while streaming
module feat_concat_stream #(
    parameter int DW    = 16,
    parameter int LEN0  = 24,
    parameter int LEN1  = 24,
    parameter int LEN2  = 42,
    parameter int TOTAL = LEN0 + LEN1 + LEN2,
    parameter int IW    = $clog2(TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           src_en,
    input  logic [LEN0*DW-1:0]   s0_vec,
    input  logic                 s0_valid,
    output logic                 s0_ready,
    input  logic [LEN1*DW-1:0]   s1_vec,
    input  logic                 s1_valid,
    output logic                 s1_ready,
    input  logic [LEN2*DW-1:0]   s2_vec,
    input  logic                 s2_valid,
    output logic                 s2_ready,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IW-1:0]        out_index,
    output logic                 out_last,
    output logic                 busy
);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_STREAM  = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);

    state_t              r_state;
    logic [2:0]          r_got;
    logic [2:0]          r_en_q;
    logic [IW-1:0]       r_index;
    logic [LEN0*DW-1:0]  r_cap0;
    logic [LEN1*DW-1:0]  r_cap1;
    logic [LEN2*DW-1:0]  r_cap2;
    logic [DW-1:0]       r_out_data;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_busy;

    logic [2:0]          w_ready;
    logic [2:0]          w_acc;
    logic [2:0]          w_got_c;
    logic                w_go;
    logic                w_fire;
    logic                w_fin;
    logic [IW-1:0]       w_index_nxt;
    logic                w_valid_nxt;
    logic [LEN0*DW-1:0]  w_cap0_nxt;
    logic [LEN1*DW-1:0]  w_cap1_nxt;
    logic [LEN2*DW-1:0]  w_cap2_nxt;
    logic [DW-1:0]       w_data_nxt;

    // Element at slot idx of the concatenated vector; disabled slots read as zero.
    function automatic logic [DW-1:0] slot_elem(
        input logic [IW-1:0]       idx,
        input logic [LEN0*DW-1:0]  c0,
        input logic [LEN1*DW-1:0]  c1,
        input logic [LEN2*DW-1:0]  c2,
        input logic [2:0]          en
    );
        logic [LEN0*DW-1:0] t0;
        logic [LEN1*DW-1:0] t1;
        logic [LEN2*DW-1:0] t2;
        int i;
        i = int'(idx);
        if (i < LEN0) begin
            t0 = c0 >> (i * DW);
            slot_elem = en[0] ? t0[DW-1:0] : '0;
        end else if (i < LEN0 + LEN1) begin
            t1 = c1 >> ((i - LEN0) * DW);
            slot_elem = en[1] ? t1[DW-1:0] : '0;
        end else begin
            t2 = c2 >> ((i - LEN0 - LEN1) * DW);
            slot_elem = en[2] ? t2[DW-1:0] : '0;
        end
    endfunction

    // Handshake decode and next-value computation for the registered outputs.
    always_comb begin
        w_ready     = 3'b000;
        w_go        = 1'b0;
        w_fire      = 1'b0;
        w_fin       = 1'b0;
        w_valid_nxt = 1'b0;
        if (r_state == ST_COLLECT) begin
            w_ready = r_en_q & ~r_got;
        end else begin
            w_ready = 3'b000;
        end
        w_acc   = w_ready & {s2_valid, s1_valid, s0_valid};
        w_got_c = r_got | w_acc;
        if (r_state == ST_COLLECT) begin
            // Every enabled source captured (including this cycle's accepts).
            w_go        = ((w_got_c & r_en_q) == r_en_q) && (r_en_q != 3'b000);
            w_valid_nxt = w_go;
        end else begin
            w_fire      = r_out_valid && out_ready;
            w_fin       = w_fire && r_out_last;
            w_valid_nxt = !w_fin;
        end
        if (w_fire && !r_out_last) begin
            w_index_nxt = r_index + IW'(1);
        end else if (w_fin) begin
            w_index_nxt = '0;
        end else begin
            w_index_nxt = r_index;
        end
        w_cap0_nxt = w_acc[0] ? s0_vec : r_cap0;
        w_cap1_nxt = w_acc[1] ? s1_vec : r_cap1;
        w_cap2_nxt = w_acc[2] ? s2_vec : r_cap2;
        // Data is looked up one cycle ahead so out_data comes straight from a flop.
        w_data_nxt = slot_elem(w_index_nxt, w_cap0_nxt, w_cap1_nxt, w_cap2_nxt, r_en_q);
    end

    // Frame FSM, capture registers and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_COLLECT;
            r_got       <= 3'b000;
            r_en_q      <= src_en;
            r_index     <= '0;
            r_cap0      <= '0;
            r_cap1      <= '0;
            r_cap2      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    r_cap0 <= w_cap0_nxt;
                    r_cap1 <= w_cap1_nxt;
                    r_cap2 <= w_cap2_nxt;
                    r_got  <= w_got_c;
                    // The enable set is frozen once the first source of a frame lands.
                    if (w_got_c == 3'b000) begin
                        r_en_q <= src_en;
                    end
                    if (w_go) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_fin) begin
                        r_state <= ST_COLLECT;
                        r_got   <= 3'b000;
                    end
                end
                default: begin
                    r_state <= ST_COLLECT;
                    r_got   <= 3'b000;
                end
            endcase
            r_index     <= w_index_nxt;
            r_out_data  <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_valid_nxt && (w_index_nxt == LAST_IDX);
            r_busy      <= w_valid_nxt;
        end
    end

    assign s0_ready  = w_ready[0];
    assign s1_ready  = w_ready[1];
    assign s2_ready  = w_ready[2];
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_index = r_index;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_feat_concat_stream.sv
module tb_feat_concat_stream;

    localparam int DW    = 16;
    localparam int LEN0  = 24;
    localparam int LEN1  = 24;
    localparam int LEN2  = 42;
    localparam int TOTAL = LEN0 + LEN1 + LEN2;
    localparam int IW    = $clog2(TOTAL);

    logic                clk = 1'b0;
    logic                rst;
    logic [2:0]          src_en;
    logic [LEN0*DW-1:0]  s0_vec;
    logic                s0_valid;
    logic                s0_ready;
    logic [LEN1*DW-1:0]  s1_vec;
    logic                s1_valid;
    logic                s1_ready;
    logic [LEN2*DW-1:0]  s2_vec;
    logic                s2_valid;
    logic                s2_ready;
    logic [DW-1:0]       out_data;
    logic                out_valid;
    logic                out_ready;
    logic [IW-1:0]       out_index;
    logic                out_last;
    logic                busy;

    feat_concat_stream #(.DW(DW), .LEN0(LEN0), .LEN1(LEN1), .LEN2(LEN2)) dut (
        .clk(clk), .rst(rst), .src_en(src_en),
        .s0_vec(s0_vec), .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s1_vec(s1_vec), .s1_valid(s1_valid), .s1_ready(s1_ready),
        .s2_vec(s2_vec), .s2_valid(s2_valid), .s2_ready(s2_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference frame: expected element for every output slot.
    logic [DW-1:0]       exp_frame [TOTAL];
    logic [2:0]          cur_en;
    bit                  pend_s0;
    logic [LEN0*DW-1:0]  pend_vec;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: optional enable change, collection with per-source arrival
    // delays (negative = random), then the stream with the chosen out_ready
    // mode (0 always, 1 pattern 1,0,0, 2 random). rst_idx>=0 resets mid-stream.
    task automatic run_frame(input logic [2:0] en, input int d0, input int d1, input int d2,
                             input int rmode, input int rst_idx, input bit hold_next,
                             input bit directed);
        int d [3];
        logic [2:0] acc;
        logic [DW-1:0] e;
        int c;
        int eidx;
        int sc;
        bit done;
        d[0] = (d0 < 0) ? int'($urandom_range(0, 8)) : d0;
        d[1] = (d1 < 0) ? int'($urandom_range(0, 8)) : d1;
        d[2] = (d2 < 0) ? int'($urandom_range(0, 8)) : d2;
        if (pend_s0) d[0] = 0;
        if (en != cur_en) begin
            src_en = en;
            s0_valid = 1'b0; s1_valid = 1'b0; s2_valid = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("en_chg_ready", {s2_ready, s1_ready, s0_ready}, cur_en);
            check("en_chg_valid", out_valid, 1'b0);
            step();
            cur_en = en;
        end
        for (int j = 0; j < LEN0; j++) begin
            if (pend_s0) e = pend_vec[j*DW +: DW];
            else e = directed ? DW'(j) : DW'($urandom);
            s0_vec[j*DW +: DW] = e;
            exp_frame[j] = en[0] ? e : '0;
        end
        for (int j = 0; j < LEN1; j++) begin
            e = directed ? DW'(100 + j) : DW'($urandom);
            s1_vec[j*DW +: DW] = e;
            exp_frame[LEN0 + j] = en[1] ? e : '0;
        end
        for (int j = 0; j < LEN2; j++) begin
            e = directed ? DW'(200 + j) : DW'($urandom);
            s2_vec[j*DW +: DW] = e;
            exp_frame[LEN0 + LEN1 + j] = en[2] ? e : '0;
        end
        acc = 3'b000;
        c = 0;
        while (acc != en) begin
            s0_valid = en[0] ? (!acc[0] && c >= d[0]) : 1'($urandom_range(0, 1));
            s1_valid = en[1] ? (!acc[1] && c >= d[1]) : 1'($urandom_range(0, 1));
            s2_valid = en[2] ? (!acc[2] && c >= d[2]) : 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("col_ready", {s2_ready, s1_ready, s0_ready}, en & ~acc);
            check("col_valid", out_valid, 1'b0);
            check("col_busy", busy, 1'b0);
            acc = acc | (en & ~acc & {s2_valid, s1_valid, s0_valid});
            step();
            c++;
        end
        pend_s0 = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0; s2_valid = 1'b0;
        eidx = 0;
        sc = 0;
        done = 1'b0;
        while (!done) begin
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = (sc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (hold_next && sc >= 3 && !s0_valid) begin
                for (int j = 0; j < LEN0; j++) pend_vec[j*DW +: DW] = DW'($urandom);
                s0_vec = pend_vec;
                s0_valid = 1'b1;
                pend_s0 = 1'b1;
            end
            if (eidx == rst_idx) begin
                out_ready = 1'b0;
                rst = 1'b1;
            end
            @(negedge clk);
            check("st_valid", out_valid, 1'b1);
            check("st_index", out_index, eidx);
            check("st_data", out_data, exp_frame[eidx]);
            check("st_last", out_last, eidx == TOTAL - 1);
            check("st_busy", busy, 1'b1);
            check("st_ready", {s2_ready, s1_ready, s0_ready}, 3'b000);
            step();
            sc++;
            if (rst) begin
                rst = 1'b0;
                done = 1'b1;
                @(negedge clk);
                check("rst_valid", out_valid, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_index", out_index, 0);
                check("rst_last", out_last, 1'b0);
                check("rst_ready", {s2_ready, s1_ready, s0_ready}, cur_en);
                step();
            end else if (out_ready) begin
                if (eidx == TOTAL - 1) done = 1'b1;
                else eidx++;
            end
            if (!done && sc > 4000) begin
                check("st_timeout", 1'b1, 1'b0);
                done = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        src_en = 3'b111;
        s0_vec = '0; s1_vec = '0; s2_vec = '0;
        s0_valid = 1'b0; s1_valid = 1'b0; s2_valid = 1'b0;
        out_ready = 1'b0;
        pend_s0 = 1'b0;
        pend_vec = '0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", out_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_last", out_last, 1'b0);
        check("reset_index", out_index, 0);
        check("reset_ready", {s2_ready, s1_ready, s0_ready}, 3'b111);
        step();
        cur_en = 3'b111;

        // All sources together, full throughput, known element values.
        run_frame(3'b111, 0, 0, 0, 0, -1, 1'b0, 1'b1);
        // Staggered arrival: s2 at 0, s0 at 5, s1 at 9.
        run_frame(3'b111, 5, 9, 0, 0, -1, 1'b0, 1'b0);
        // Source 1 disabled: its slots stream as zeros, its valid is ignored.
        run_frame(3'b101, 0, 3, 0, 0, -1, 1'b0, 1'b1);
        // Backpressure 1,0,0 with the next frame's s0 held during the stream.
        run_frame(3'b101, 2, 0, 1, 1, -1, 1'b1, 1'b0);
        run_frame(3'b101, 0, 0, 0, 2, -1, 1'b0, 1'b0);
        // Reset in the middle of the stream, then a fresh frame.
        run_frame(3'b111, -1, -1, -1, 2, 40, 1'b0, 1'b0);
        run_frame(3'b111, -1, -1, -1, 2, -1, 1'b0, 1'b0);

        // Nothing enabled: valids held, nothing accepted, nothing streamed.
        src_en = 3'b000;
        @(negedge clk);
        check("en0_chg_ready", {s2_ready, s1_ready, s0_ready}, cur_en);
        step();
        cur_en = 3'b000;
        for (int i = 0; i < 50; i++) begin
            s0_valid = 1'b1; s1_valid = 1'b1; s2_valid = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("en0_ready", {s2_ready, s1_ready, s0_ready}, 3'b000);
            check("en0_valid", out_valid, 1'b0);
            step();
        end
        run_frame(3'b010, 0, 0, 0, 0, -1, 1'b0, 1'b1);

        // Randomized frames.
        for (int i = 0; i < 6; i++) begin
            run_frame(3'($urandom_range(1, 7)), -1, -1, -1, 2, -1, 1'b0, 1'b0);
        end

        out_ready = 1'b1;
        @(negedge clk);
        check("end_valid", out_valid, 1'b0);
        check("end_busy", busy, 1'b0);
        check("end_ready", {s2_ready, s1_ready, s0_ready}, cur_en);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
